// File: rtl/rw_timing_sched_if.sv
// rtl/rw_timing_sched_if.sv - host/encoder handshake bundle for the DRAM timing scheduler
//
// Purpose: groups the host request handshake and the per-cycle command strobes
//          of rw_timing_sched into one bundle.
// Signals:
//   cmd_rdy      host -> sched  request valid (host holds it until accepted)
//   request      host -> sched  2-bit request code: 0=RD 1=WR 2=RDA 3=WRA
//   busy         sched -> host  high = request will not be accepted this cycle
//   cur_req      sched -> enc   request latched at acceptance
//   act_rdy      sched -> enc   1-cycle strobe: issue ACT
//   cas_rdy      sched -> enc   1-cycle strobe: issue RD/WR/RDA/WRA per cur_req
//   pre_rdy      sched -> enc   1-cycle strobe: issue PRE
//   refresh_rdy  sched -> enc   1-cycle strobe: issue REF
//   des_rdy      sched -> enc   high whenever no other strobe is high
//   ref_overflow sched -> host  sticky: refresh demand exceeded the postpone limit
interface rw_timing_sched_if;
   logic       cmd_rdy;
   logic [1:0] request;
   logic       busy;
   logic [1:0] cur_req;
   logic       act_rdy;
   logic       cas_rdy;
   logic       pre_rdy;
   logic       refresh_rdy;
   logic       des_rdy;
   logic       ref_overflow;

   modport master (
      output cmd_rdy, request,
      input  busy, cur_req, act_rdy, cas_rdy, pre_rdy, refresh_rdy, des_rdy, ref_overflow
   );

   modport slave (
      input  cmd_rdy, request,
      output busy, cur_req, act_rdy, cas_rdy, pre_rdy, refresh_rdy, des_rdy, ref_overflow
   );
endinterface

// File: rtl/rw_timing_sched.sv
// rtl/rw_timing_sched.sv - per-request DRAM timing scheduler with refresh timer
//
// Purpose: accepts one host RD/WR/RDA/WRA request at a time and sequences
//          ACT -> CAS -> PRE while enforcing tRCD, tRAS, RD/WR-to-PRE, tRP and
//          tRFC. Owns the periodic refresh timer and the postponed-refresh count.
// Ports:
//   i_clk  in  clock, rising edge
//   i_rst  in  asynchronous active-high reset
//   bus    slave modport of rw_timing_sched_if (request handshake + strobes)
module rw_timing_sched #(
   parameter int TRCD    = 11,
   parameter int TRAS    = 28,
   parameter int TRP     = 11,
   parameter int RD2PRE  = 6,
   parameter int WR2PRE  = 25,
   parameter int TRFC    = 160,
   parameter int TREFI   = 6240,
   parameter int MAXPEND = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   rw_timing_sched_if.slave bus
);
   localparam int TW = (TREFI > 1) ? $clog2(TREFI) : 1;
   localparam int PW = $clog2(MAXPEND + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ACT, S_TRCD, S_CAS, S_TWAIT, S_PRE, S_TRP, S_REF, S_TRFC
   } state_t;

   state_t        r_state;
   logic [15:0]   r_cnt;      // remaining cycles of the current tRCD/tRP/tRFC wait
   logic [7:0]    r_ras_cnt;  // remaining cycles until the tRAS term allows precharge
   logic [7:0]    r_x_cnt;    // remaining cycles until the CAS-to-PRE term allows precharge
   logic [TW-1:0] r_timer;
   logic [PW-1:0] r_pend;
   logic [1:0]    r_cur_req;
   logic          r_act;
   logic          r_cas;
   logic          r_pre;
   logic          r_ref;
   logic          r_des;
   logic          r_ovf;

   logic w_busy;
   logic w_wrap;
   logic w_ref_go;
   logic w_pre_ok;

   assign w_busy   = (r_state != S_IDLE) || (r_pend != '0);
   assign w_wrap   = (r_timer == TW'(TREFI - 1));
   assign w_ref_go = (r_state == S_IDLE) && (r_pend != '0);
   // Precharge point is the later of ACT+tRAS and CAS+X; both counters must be spent.
   assign w_pre_ok = (r_ras_cnt == 8'd0) && (r_x_cnt == 8'd0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_ras_cnt <= '0;
         r_x_cnt   <= '0;
         r_timer   <= '0;
         r_pend    <= '0;
         r_cur_req <= '0;
         r_act     <= 1'b0;
         r_cas     <= 1'b0;
         r_pre     <= 1'b0;
         r_ref     <= 1'b0;
         r_des     <= 1'b1;
         r_ovf     <= 1'b0;
      end else begin
         r_timer <= w_wrap ? '0 : r_timer + 1'b1;

         // A wrap coinciding with a REF launch leaves the pending count unchanged.
         if (w_wrap && !w_ref_go) begin
            if (r_pend == PW'(MAXPEND)) r_ovf <= 1'b1;
            else                        r_pend <= r_pend + 1'b1;
         end else if (w_ref_go && !w_wrap) begin
            r_pend <= r_pend - 1'b1;
         end

         if (r_ras_cnt != 8'd0) r_ras_cnt <= r_ras_cnt - 1'b1;
         if (r_x_cnt != 8'd0)   r_x_cnt   <= r_x_cnt - 1'b1;

         r_act <= 1'b0;
         r_cas <= 1'b0;
         r_pre <= 1'b0;
         r_ref <= 1'b0;
         r_des <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_ref_go) begin
                  r_state <= S_REF;
                  r_ref   <= 1'b1;
                  r_des   <= 1'b0;
                  r_cnt   <= 16'(TRFC - 1);
               end else if (bus.cmd_rdy) begin
                  r_cur_req <= bus.request;
                  r_state   <= S_ACT;
                  r_act     <= 1'b1;
                  r_des     <= 1'b0;
                  r_cnt     <= 16'(TRCD - 1);
                  r_ras_cnt <= 8'(TRAS - 1);
               end
            end
            S_ACT, S_TRCD: begin
               if (r_cnt == 16'd0) begin
                  r_state <= S_CAS;
                  r_cas   <= 1'b1;
                  r_des   <= 1'b0;
                  // request bit 0 selects write timing
                  r_x_cnt <= r_cur_req[0] ? 8'(WR2PRE - 1) : 8'(RD2PRE - 1);
               end else begin
                  r_cnt   <= r_cnt - 1'b1;
                  r_state <= S_TRCD;
               end
            end
            S_CAS, S_TWAIT: begin
               if (w_pre_ok) begin
                  r_cnt <= 16'(TRP - 1);
                  // request bit 1 marks auto-precharge: the device closes the row itself
                  if (r_cur_req[1]) begin
                     r_state <= S_TRP;
                  end else begin
                     r_state <= S_PRE;
                     r_pre   <= 1'b1;
                     r_des   <= 1'b0;
                  end
               end else begin
                  r_state <= S_TWAIT;
               end
            end
            S_PRE, S_TRP: begin
               if (r_cnt == 16'd0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt   <= r_cnt - 1'b1;
                  r_state <= S_TRP;
               end
            end
            S_REF, S_TRFC: begin
               if (r_cnt == 16'd0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt   <= r_cnt - 1'b1;
                  r_state <= S_TRFC;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy         = w_busy;
   assign bus.cur_req      = r_cur_req;
   assign bus.act_rdy      = r_act;
   assign bus.cas_rdy      = r_cas;
   assign bus.pre_rdy      = r_pre;
   assign bus.refresh_rdy  = r_ref;
   assign bus.des_rdy      = r_des;
   assign bus.ref_overflow = r_ovf;
endmodule

// File: tb/tb_rw_timing_sched.sv
// tb/tb_rw_timing_sched.sv - scoreboard bench for rw_timing_sched
module tb_rw_timing_sched;
   localparam logic [1:0] RD_R = 2'd0, WR_R = 2'd1, RDA_R = 2'd2;
   localparam int TRFC_A = 20;
   localparam int K_ACT = 0, K_CAS = 1, K_PRE = 2, K_REF = 3, K_BUP = 4, K_BDN = 5;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   rw_timing_sched_if ifa ();
   rw_timing_sched_if ifb ();

   rw_timing_sched #(.TREFI(100), .TRFC(TRFC_A)) u_dut_a (
      .i_clk(clk), .i_rst(rst_a), .bus(ifa)
   );
   rw_timing_sched #(.TREFI(25), .TRFC(1), .WR2PRE(230)) u_dut_b (
      .i_clk(clk), .i_rst(rst_b), .bus(ifb)
   );

   int n_vec  = 0;
   int n_fail = 0;
   int cyc_a  = 0;
   int cyc_b  = 0;
   bit mon_en = 1'b0;
   bit b_done = 1'b0;
   logic prev_busy = 1'b0;

   int         q_act[$];
   int         q_cas[$];
   logic [1:0] q_casreq[$];
   int         q_pre[$];
   int         q_ref[$];
   int         q_bup[$];
   int         q_bdn[$];

   always @(posedge clk) begin
      if (rst_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;
      if (rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;
   end

   function automatic string kname(input int k);
      case (k)
         K_ACT: return "act_rdy";
         K_CAS: return "cas_rdy";
         K_PRE: return "pre_rdy";
         K_REF: return "refresh_rdy";
         K_BUP: return "busy_rise";
         default: return "busy_fall";
      endcase
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   task automatic pop_cmp(input int k, input logic [1:0] req);
      int         exp_c = -1;
      logic [1:0] exp_r = 2'd0;
      bit         empty = 1'b0;
      case (k)
         K_ACT: if (q_act.size() == 0) empty = 1'b1; else exp_c = q_act.pop_front();
         K_CAS: if (q_cas.size() == 0) empty = 1'b1;
                else begin exp_c = q_cas.pop_front(); exp_r = q_casreq.pop_front(); end
         K_PRE: if (q_pre.size() == 0) empty = 1'b1; else exp_c = q_pre.pop_front();
         K_REF: if (q_ref.size() == 0) empty = 1'b1; else exp_c = q_ref.pop_front();
         K_BUP: if (q_bup.size() == 0) empty = 1'b1; else exp_c = q_bup.pop_front();
         default: if (q_bdn.size() == 0) empty = 1'b1; else exp_c = q_bdn.pop_front();
      endcase
      n_vec++;
      if (empty) begin
         n_fail++;
         $display("FAIL %s: unexpected at cycle %0d, want none", kname(k), cyc_a);
      end else if (exp_c != cyc_a) begin
         n_fail++;
         $display("FAIL %s: got cycle %0d, want cycle %0d", kname(k), cyc_a, exp_c);
      end else if (k == K_CAS && req != exp_r) begin
         n_fail++;
         $display("FAIL cur_req at cas: got %0d, want %0d", req, exp_r);
      end
   endtask

   // Monitor: every observed strobe or busy edge of DUT A is matched against the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ifa.busy && !prev_busy) pop_cmp(K_BUP, 2'd0);
         if (!ifa.busy && prev_busy) pop_cmp(K_BDN, 2'd0);
         if (ifa.act_rdy)     pop_cmp(K_ACT, 2'd0);
         if (ifa.cas_rdy)     pop_cmp(K_CAS, ifa.cur_req);
         if (ifa.pre_rdy)     pop_cmp(K_PRE, 2'd0);
         if (ifa.refresh_rdy) pop_cmp(K_REF, 2'd0);
         prev_busy = ifa.busy;
      end
   end

   task automatic wait_cyc_a(input int n);
      while (cyc_a < n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_cyc_b(input int n);
      while (cyc_b < n) begin @(posedge clk); #1; end
   endtask

   task automatic exp_refresh(input int t);
      q_bup.push_back(t);
      q_ref.push_back(t + 1);
      q_bdn.push_back(t + 1 + TRFC_A);
   endtask

   // Hand-derived offsets from acceptance T: ACT T+1, CAS T+12,
   // PRE T+29 (RD, tRAS-bound) / T+37 (WR, write-recovery-bound), idle T+40 / T+48.
   task automatic expect_cmd(input logic [1:0] r, input int t);
      q_bup.push_back(t + 1);
      q_act.push_back(t + 1);
      q_cas.push_back(t + 12);
      q_casreq.push_back(r);
      if (!r[1]) q_pre.push_back(r[0] ? t + 37 : t + 29);
      q_bdn.push_back(r[0] ? t + 48 : t + 40);
   endtask

   task automatic issue(input logic [1:0] r, input int from, input int t_acc);
      wait_cyc_a(from);
      ifa.cmd_rdy = 1'b1;
      ifa.request = r;
      wait_cyc_a(t_acc + 1);
      ifa.cmd_rdy = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_act"}, ifa.act_rdy, 0);
      chk({tag, "_cas"}, ifa.cas_rdy, 0);
      chk({tag, "_pre"}, ifa.pre_rdy, 0);
      chk({tag, "_ref"}, ifa.refresh_rdy, 0);
      chk({tag, "_des"}, ifa.des_rdy, 1);
      chk({tag, "_busy"}, ifa.busy, 0);
   endtask

   // DUT B: a long write spans ten refresh wraps, overflowing the postpone count.
   initial begin
      int nref;
      int act_at;
      ifb.cmd_rdy = 1'b1;
      ifb.request = WR_R;
      wait (!rst_b);
      @(posedge clk); #1;
      ifb.cmd_rdy = 1'b0;
      @(negedge clk);
      chk("b_wr_act_cycle1", ifb.act_rdy, 1);
      wait_cyc_b(224);
      @(negedge clk);
      chk("b_ovf_before_9th_wrap", ifb.ref_overflow, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b_ovf_after_9th_wrap", ifb.ref_overflow, 1);
      wait_cyc_b(250);
      ifb.cmd_rdy = 1'b1;
      ifb.request = RD_R;
      nref   = 0;
      act_at = -1;
      for (int i = 0; i < 400 && act_at < 0; i++) begin
         @(negedge clk);
         if (ifb.refresh_rdy) nref++;
         if (ifb.act_rdy) act_at = cyc_b;
      end
      ifb.cmd_rdy = 1'b0;
      chk("b_next_act_cycle", act_at, 270);
      chk("b_refs_before_cmd", nref, 8);
      chk("b_ovf_sticky", ifb.ref_overflow, 1);
      b_done = 1'b1;
   end

   initial begin
      ifa.cmd_rdy = 1'b0;
      ifa.request = RD_R;
      repeat (3) @(posedge clk);
      #1;
      rst_a  = 1'b0;
      rst_b  = 1'b0;
      mon_en = 1'b1;

      chk_idle_outputs("reset");
      chk("reset_cur_req", ifa.cur_req, 0);
      chk("reset_ovf", ifa.ref_overflow, 0);

      exp_refresh(100);
      expect_cmd(RD_R, 130);
      issue(RD_R, 130, 130);

      // WR held during a refresh: accepted on the very edge busy drops.
      exp_refresh(200);
      expect_cmd(WR_R, 221);
      issue(WR_R, 210, 221);
      wait_cyc_a(245);
      @(negedge clk);
      chk("twait_busy", ifa.busy, 1);
      chk("twait_des", ifa.des_rdy, 1);

      exp_refresh(300);
      expect_cmd(RDA_R, 330);
      issue(RDA_R, 330, 330);

      // RD aborted by reset five cycles after acceptance.
      exp_refresh(400);
      q_bup.push_back(431);
      q_act.push_back(431);
      q_bdn.push_back(435);
      issue(RD_R, 430, 430);
      wait_cyc_a(435);
      rst_a = 1'b1;
      #1;
      chk_idle_outputs("abort");
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b0;

      expect_cmd(RD_R, 10);
      exp_refresh(100);
      issue(RD_R, 10, 10);
      wait_cyc_a(130);

      chk("left_act", q_act.size(), 0);
      chk("left_cas", q_cas.size(), 0);
      chk("left_pre", q_pre.size(), 0);
      chk("left_ref", q_ref.size(), 0);
      chk("left_busy_rise", q_bup.size(), 0);
      chk("left_busy_fall", q_bdn.size(), 0);

      for (int i = 0; i < 1000 && !b_done; i++) @(posedge clk);
      chk("b_finished", b_done, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
